// File: rtl/key_if.sv
// Push-button bundle between the raw KEY pins and the conditioned key outputs.
// The slave modport is the conditioner; the master modport drives key_n and observes the outputs.
interface key_if #(
  parameter int unsigned NKEYS = 3
);
  logic [NKEYS-1:0] key_n;
  logic [NKEYS-1:0] key_level;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;
  logic             key_any;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_any
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output key_any
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key 2-flop synchroniser, debounce FSM and press/release pulse generator.
// Define KEY_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_conditioner #(
  parameter int unsigned NKEYS           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic  clk,
  input logic  rst_n,
  key_if.slave kif
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StReleased, StPressPend, StPressed, StReleasePend} state_e;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $fatal(1, "key_conditioner: DEBOUNCE_CYCLES must be >=2, REPEAT_* must be >=1");
  end

  logic [NKEYS-1:0] level_vec, press_vec, release_vec, press_d_vec;
  logic             any_q;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    logic            sync1_q, s_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            rep_fire;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        StReleased: begin
          if (!s_q) begin
            state_d = StPressPend;
            cnt_d   = CntW'(1);
          end
        end
        StPressPend: begin
          if (s_q) begin
            state_d = StReleased;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StPressed;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (s_q) begin
            state_d = StReleasePend;
            cnt_d   = CntW'(1);
          end else begin
            press_d = rep_fire;
          end
        end
        StReleasePend: begin
          if (!s_q) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StReleased;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StReleased;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned HoldW = $clog2(HoldMax + 1);
    localparam logic [HoldW-1:0] DelayLast  = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] PeriodLast = HoldW'(REPEAT_PERIOD - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             repeating_q, repeating_d;
    logic             hold_run;

    // Hold time only accumulates while the key stays in PRESSED; any exit or re-entry restarts it.
    assign hold_run = (state_q == StPressed) && (state_d == StPressed);
    assign rep_fire = repeating_q ? (hold_q == PeriodLast) : (hold_q == DelayLast);

    always_comb begin
      hold_d      = hold_q;
      repeating_d = repeating_q;
      if (!hold_run) begin
        hold_d      = '0;
        repeating_d = 1'b0;
      end else if (rep_fire) begin
        hold_d      = '0;
        repeating_d = 1'b1;
      end else begin
        hold_d = hold_q + HoldW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q      <= '0;
        repeating_q <= 1'b0;
      end else begin
        hold_q      <= hold_d;
        repeating_q <= repeating_d;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Sync flops reset to "released" so a key held through reset reads as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        s_q     <= 1'b1;
        state_q <= StReleased;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync1_q <= kif.key_n[i];
        s_q     <= sync1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign level_vec[i]   = level_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = rel_q;
    assign press_d_vec[i] = press_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |press_d_vec;
    end
  end

  assign kif.key_level   = level_vec;
  assign kif.key_press   = press_vec;
  assign kif.key_release = release_vec;
  assign kif.key_any     = any_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner against a run-length debounce model.
// Build with KEY_REPEAT_EN defined to exercise auto-repeat.
module tb_key_conditioner;
  localparam int unsigned NK = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;
`ifdef KEY_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  key_if #(.NKEYS(NK)) kif ();

  key_conditioner #(
    .NKEYS          (NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kif  (kif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: synchronised sample is the raw value from two edges ago; a key's level flips once
  // DB consecutive samples disagree with it. Hold time counts edges of undisturbed press.
  logic [NK-1:0] m_h1, m_h2, m_level, m_press, m_rel;
  int            m_run [NK];
  int            m_hold[NK];
  int            press_seen[NK];
  int            rel_seen[NK];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    logic [NK-1:0] s;
    logic          want;
    if (!rst_n) begin
      m_h1 = '1;
      m_h2 = '1;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < NK; k++) begin
        m_run[k]  = 0;
        m_hold[k] = 0;
      end
      return;
    end
    s       = m_h2;
    m_h2    = m_h1;
    m_h1    = kif.key_n;
    m_press = '0;
    m_rel   = '0;
    for (int k = 0; k < NK; k++) begin
      want = ~s[k];
      if (want != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_level[k] = want;
          m_run[k]   = 0;
          m_hold[k]  = 0;
          if (want) m_press[k] = 1'b1;
          else      m_rel[k]   = 1'b1;
        end
      end else begin
        if (m_level[k]) begin
          if (m_run[k] > 0) begin
            m_hold[k] = 0;
          end else begin
            m_hold[k]++;
            if (RepEn && m_hold[k] >= RD && ((m_hold[k] - RD) % RP) == 0) m_press[k] = 1'b1;
          end
        end
        m_run[k] = 0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      press_seen[k] = 0;
      rel_seen[k]   = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("key_level", kif.key_level, m_level);
      check("key_press", kif.key_press, m_press);
      check("key_release", kif.key_release, m_rel);
      check("key_any", kif.key_any, |m_press);
      for (int k = 0; k < NK; k++) begin
        if (kif.key_press[k]) press_seen[k]++;
        if (kif.key_release[k]) rel_seen[k]++;
      end
    end
  end

  task automatic posedges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int snap;
    int tot;
    kif.key_n = '1;

    // Reset then idle keys for 20 cycles.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_level", kif.key_level, 0);
    tot = press_seen[0] + press_seen[1] + press_seen[2] + rel_seen[0] + rel_seen[1] + rel_seen[2];
    check("idle_pulses", tot, 0);

    // Single press on key 0: pulse after the 6th edge.
    @(negedge clk);
    kif.key_n = 3'b110;
    posedges(5);
    check("k0_press_early", kif.key_press, 3'b000);
    posedges(1);
    check("k0_press", kif.key_press, 3'b001);
    check("k0_any", kif.key_any, 1'b1);
    posedges(1);
    check("k0_press_once", kif.key_press, 3'b000);
    check("k0_level", kif.key_level, 3'b001);
    @(negedge clk);
    kif.key_n = 3'b111;
    repeat (12) @(negedge clk);

    // Bounce on key 1 never long enough to accept.
    snap = press_seen[1];
    kif.key_n = 3'b101;
    repeat (3) @(negedge clk);
    kif.key_n = 3'b111;
    @(negedge clk);
    kif.key_n = 3'b101;
    repeat (2) @(negedge clk);
    kif.key_n = 3'b111;
    repeat (12) @(negedge clk);
    check("k1_bounce_press", press_seen[1] - snap, 0);
    check("k1_bounce_level", kif.key_level, 3'b000);

    // Keys 0 and 2 together.
    kif.key_n = 3'b010;
    posedges(6);
    check("k02_press", kif.key_press, 3'b101);
    check("k02_any", kif.key_any, 1'b1);
    repeat (14) @(negedge clk);
    kif.key_n = 3'b111;
    posedges(6);
    check("k02_release", kif.key_release, 3'b101);
    check("k02_release_nopress", kif.key_press, 3'b000);
    repeat (10) @(negedge clk);

    // Reset while key 1 is held.
    kif.key_n = 3'b101;
    repeat (12) @(negedge clk);
    check("k1_held_level", kif.key_level, 3'b010);
    snap = rel_seen[1];
    rst_n = 1'b0;
    #1;
    check("rst_level", kif.key_level, 3'b000);
    check("rst_press", kif.key_press, 3'b000);
    check("rst_any", kif.key_any, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    posedges(5);
    check("postrst_early", kif.key_press, 3'b000);
    posedges(1);
    check("postrst_press", kif.key_press, 3'b010);
    repeat (3) @(negedge clk);
    check("postrst_norelease", rel_seen[1] - snap, 0);
    kif.key_n = 3'b111;
    repeat (12) @(negedge clk);

    // Long hold on key 2: accept pulse plus repeats when enabled.
    snap = press_seen[2];
    kif.key_n = 3'b011;
    posedges(36);
    check("k2_hold_pulses", press_seen[2] - snap, RepEn ? 6 : 1);
    @(negedge clk);
    kif.key_n = 3'b111;
    repeat (12) @(negedge clk);

    // Random key activity with occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 7) == 0) kif.key_n[k] = ~kif.key_n[k];
      end
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    rst_n = 1'b1;
    kif.key_n = '1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
